// File: rtl/instr_mem_server_pkg.sv
// Shared widths, NOP encoding, FSM state encoding and read-pipe payload for the instruction memory.
package instr_mem_server_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  localparam logic [DATA_W-1:0] NOP = 16'h0000;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } rd_beat_t;

endpackage

// File: rtl/instr_mem_server_if.sv
// Fetch and program-load signals between the fetch stage / loader and the instruction memory.
interface instr_mem_server_if;
  import instr_mem_server_pkg::*;

  logic              fetch_req;
  logic [ADDR_W-1:0] instr_addr;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_done;
  logic              ready;
  logic              load_err;

  modport master (
    output fetch_req, instr_addr, load_en, load_addr, load_data, load_done,
    input  instr, instr_valid, ready, load_err
  );

  modport slave (
    input  fetch_req, instr_addr, load_en, load_addr, load_data, load_done,
    output instr, instr_valid, ready, load_err
  );

endinterface

// File: rtl/instr_mem_rd_pipe.sv
// READ_LAT-deep {valid, data} delay line; instr only updates when a valid beat emerges.
module instr_mem_rd_pipe
  import instr_mem_server_pkg::*;
#(
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  rd_beat_t          in_beat,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid
);

  rd_beat_t tail_c;

  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
    $error("instr_mem_rd_pipe: READ_LAT must be 1..4");
  end

  // Intermediate stages; the output register supplies the final cycle of latency.
  if (READ_LAT > 1) begin : g_stages
    rd_beat_t stage_q [READ_LAT-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(READ_LAT) - 1; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= in_beat;
        for (int i = 1; i < int'(READ_LAT) - 1; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign tail_c = stage_q[READ_LAT-2];
  end else begin : g_direct
    assign tail_c = in_beat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid <= 1'b0;
      instr       <= NOP;
    end else begin
      instr_valid <= tail_c.valid;
      if (tail_c.valid) instr <= tail_c.data;
    end
  end

endmodule

// File: rtl/instr_mem_server.sv
// Instruction memory responder: program load in LOAD, fixed-latency fetch responses in RUN.
module instr_mem_server
  import instr_mem_server_pkg::*;
#(
  parameter int unsigned READ_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  instr_mem_server_if.slave  bus
);

  state_e            state_q;
  state_e            state_d;
  logic              wr_en_c;
  logic              accept_c;
  logic              err_set_c;
  logic              load_err_q;
  logic [DEPTH-1:0]  written_q;
  logic [DATA_W-1:0] mem [DEPTH];
  rd_beat_t          rd_beat_c;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  // RUN is only left through reset.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_LOAD && bus.load_done) state_d = ST_RUN;
  end

  always_comb begin
    wr_en_c   = 1'b0;
    accept_c  = 1'b0;
    err_set_c = 1'b0;
    case (state_q)
      ST_LOAD: wr_en_c = bus.load_en;
      ST_RUN: begin
        accept_c  = bus.fetch_req;
        err_set_c = bus.load_en;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[bus.load_addr] <= bus.load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      written_q  <= '0;
      load_err_q <= 1'b0;
    end else begin
      if (wr_en_c)   written_q[bus.load_addr] <= 1'b1;
      if (err_set_c) load_err_q <= 1'b1;
    end
  end

  // Unwritten words read as NOP so stale array contents never leak after a reset.
  always_comb begin
    rd_beat_c.valid = accept_c;
    rd_beat_c.data  = written_q[bus.instr_addr] ? mem[bus.instr_addr] : NOP;
  end

  instr_mem_rd_pipe #(.READ_LAT(READ_LAT)) u_rd_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_beat     (rd_beat_c),
    .instr       (bus.instr),
    .instr_valid (bus.instr_valid)
  );

  assign bus.ready    = (state_q == ST_RUN);
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_instr_mem_server.sv
// Drives identical stimulus into READ_LAT=1 and READ_LAT=3 instances and checks both against a cycle-indexed model.
module tb_instr_mem_server;
  import instr_mem_server_pkg::*;

  localparam int NCYC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              fetch_req;
  logic [ADDR_W-1:0] instr_addr;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_done;

  instr_mem_server_if bus1();
  instr_mem_server_if bus3();

  assign bus1.fetch_req  = fetch_req;
  assign bus1.instr_addr = instr_addr;
  assign bus1.load_en    = load_en;
  assign bus1.load_addr  = load_addr;
  assign bus1.load_data  = load_data;
  assign bus1.load_done  = load_done;
  assign bus3.fetch_req  = fetch_req;
  assign bus3.instr_addr = instr_addr;
  assign bus3.load_en    = load_en;
  assign bus3.load_addr  = load_addr;
  assign bus3.load_data  = load_data;
  assign bus3.load_done  = load_done;

  instr_mem_server #(.READ_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  instr_mem_server #(.READ_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int total = 0;
  int bad   = 0;

  // Model: memory contents, written flags, mode, sticky error, and per-edge accepted responses.
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_wr  [DEPTH];
  bit                m_run;
  bit                m_err;
  bit                acc_v [NCYC];
  logic [DATA_W-1:0] acc_d [NCYC];
  int                n        = 0;
  int                last_rst = -1;
  bit                e_v1, e_v3;
  logic [DATA_W-1:0] e_i1, e_i3;

  task automatic step();
    int k;
    @(posedge clk);
    n++;
    if (n >= NCYC) begin
      $display("FAIL cycle_budget: reached %0d cycles, limit %0d", n, NCYC);
      $fatal(1);
    end
    acc_v[n] = 1'b0;
    if (rst) begin
      m_run    = 1'b0;
      m_err    = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) m_wr[i] = 1'b0;
      last_rst = n;
    end else if (!m_run) begin
      if (load_en) begin
        m_mem[load_addr] = load_data;
        m_wr[load_addr]  = 1'b1;
      end
      if (load_done) m_run = 1'b1;
    end else begin
      if (load_en) m_err = 1'b1;
      if (fetch_req) begin
        acc_v[n] = 1'b1;
        acc_d[n] = m_wr[instr_addr] ? m_mem[instr_addr] : 16'h0000;
      end
    end
    // A response appears READ_LAT-1 edges after its accept edge unless a reset intervened.
    k = n;
    e_v1 = (k > last_rst) ? acc_v[k] : 1'b0;
    if (rst) e_i1 = 16'h0000;
    else if (e_v1) e_i1 = acc_d[k];
    k = n - 2;
    e_v3 = (k > last_rst && k >= 0) ? acc_v[k] : 1'b0;
    if (rst) e_i3 = 16'h0000;
    else if (e_v3) e_i3 = acc_d[k];
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req = 1'b0; instr_addr = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (bus1.ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus1.ready); end
    total++; if (bus1.instr !== 16'h0000) begin bad++; $display("FAIL reset_instr: got %h want 0000", bus1.instr); end
    total++; if (bus1.instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus1.instr_valid); end
    total++; if (bus1.load_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus1.load_err); end
    total++; if (bus3.instr_valid !== 1'b0 || bus3.instr !== 16'h0000) begin
      bad++; $display("FAIL reset_lat3: got valid=%b instr=%h want 0/0000", bus3.instr_valid, bus3.instr);
    end
  endtask

  task automatic test_load_fetch();
    load_en = 1'b1; load_addr = 8'h00; load_data = 16'hA1B2; step();
    load_addr = 8'h01; load_data = 16'h1234; step();
    load_en = 1'b0;
    total++; if (bus1.ready !== 1'b0) begin bad++; $display("FAIL load_ready_low: got %b want 0", bus1.ready); end
    load_done = 1'b1; step();
    load_done = 1'b0;
    total++; if (bus1.ready !== 1'b1) begin bad++; $display("FAIL load_done_ready: got %b want 1", bus1.ready); end
    fetch_req = 1'b1; instr_addr = 8'h01; step();
    fetch_req = 1'b0;
    total++; if (bus1.instr_valid !== 1'b1 || bus1.instr !== 16'h1234) begin
      bad++; $display("FAIL first_fetch: got valid=%b instr=%h want 1/1234", bus1.instr_valid, bus1.instr);
    end
    step(); step();
    total++; if (bus3.instr_valid !== 1'b1 || bus3.instr !== 16'h1234) begin
      bad++; $display("FAIL first_fetch_lat3: got valid=%b instr=%h want 1/1234", bus3.instr_valid, bus3.instr);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [3];
    logic [DATA_W-1:0] want  [3];
    addrs[0] = 8'h00; addrs[1] = 8'h01; addrs[2] = 8'hFF;
    want[0]  = 16'hA1B2; want[1] = 16'h1234; want[2] = 16'h0000;
    fetch_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) instr_addr = addrs[i]; else fetch_req = 1'b0;
      step();
      if (i < 3) begin
        total++; if (bus1.instr_valid !== 1'b1 || bus1.instr !== want[i]) begin
          bad++; $display("FAIL b2b_lat1[%0d]: got valid=%b instr=%h want 1/%h", i, bus1.instr_valid, bus1.instr, want[i]);
        end
      end
      if (i >= 2) begin
        total++; if (bus3.instr_valid !== 1'b1 || bus3.instr !== want[i-2]) begin
          bad++; $display("FAIL b2b_lat3[%0d]: got valid=%b instr=%h want 1/%h", i-2, bus3.instr_valid, bus3.instr, want[i-2]);
        end
      end
    end
    step();
    total++; if (bus1.instr_valid !== 1'b0 || bus1.instr !== 16'h0000) begin
      bad++; $display("FAIL b2b_hold: got valid=%b instr=%h want 0/0000", bus1.instr_valid, bus1.instr);
    end
  endtask

  task automatic test_err_and_load_ignore();
    load_en = 1'b1; load_addr = 8'h00; load_data = 16'h5555; step();
    load_en = 1'b0;
    total++; if (bus1.load_err !== 1'b1 || bus3.load_err !== 1'b1) begin
      bad++; $display("FAIL run_load_err: got %b/%b want 1/1", bus1.load_err, bus3.load_err);
    end
    fetch_req = 1'b1; instr_addr = 8'h00; step();
    fetch_req = 1'b0;
    total++; if (bus1.instr_valid !== 1'b1 || bus1.instr !== 16'hA1B2) begin
      bad++; $display("FAIL run_load_nowrite: got valid=%b instr=%h want 1/A1B2", bus1.instr_valid, bus1.instr);
    end
    step();
    total++; if (bus1.load_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", bus1.load_err); end
    rst = 1'b1; step(); rst = 1'b0;
    total++; if (bus1.load_err !== 1'b0 || bus1.ready !== 1'b0) begin
      bad++; $display("FAIL err_rst_clear: got err=%b ready=%b want 0/0", bus1.load_err, bus1.ready);
    end
    fetch_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      instr_addr = 8'(i);
      step();
      total++; if (bus1.instr_valid !== 1'b0 || bus3.instr_valid !== 1'b0) begin
        bad++; $display("FAIL load_fetch_ignored[%0d]: got %b/%b want 0/0", i, bus1.instr_valid, bus3.instr_valid);
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_flush();
    load_en = 1'b1; load_addr = 8'h00; load_data = 16'hCAFE; load_done = 1'b1; step();
    load_en = 1'b0; load_done = 1'b0;
    fetch_req = 1'b1; instr_addr = 8'h00; step();
    instr_addr = 8'h01; step();
    fetch_req = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++; if (bus3.instr_valid !== 1'b0) begin
        bad++; $display("FAIL flush_lat3[%0d]: got valid=%b want 0", i, bus3.instr_valid);
      end
      step();
    end
    load_done = 1'b1; step();
    load_done = 1'b0;
    fetch_req = 1'b1; instr_addr = 8'h00; step();
    fetch_req = 1'b0;
    total++; if (bus1.instr_valid !== 1'b1 || bus1.instr !== 16'h0000) begin
      bad++; $display("FAIL relaunch_nop: got valid=%b instr=%h want 1/0000", bus1.instr_valid, bus1.instr);
    end
    step();
    total++; if (bus3.instr_valid !== 1'b0) begin bad++; $display("FAIL relaunch_lat3_early: got %b want 0", bus3.instr_valid); end
    step();
    total++; if (bus3.instr_valid !== 1'b1 || bus3.instr !== 16'h0000) begin
      bad++; $display("FAIL relaunch_lat3: got valid=%b instr=%h want 1/0000", bus3.instr_valid, bus3.instr);
    end
  endtask

  task automatic test_load_done_same_cycle();
    rst = 1'b1; step(); rst = 1'b0;
    load_en = 1'b1; load_addr = 8'h10; load_data = 16'hBEEF; load_done = 1'b1;
    fetch_req = 1'b1; instr_addr = 8'h10;
    step();
    load_en = 1'b0; load_done = 1'b0;
    total++; if (bus1.ready !== 1'b1) begin bad++; $display("FAIL same_cycle_ready: got %b want 1", bus1.ready); end
    total++; if (bus1.instr_valid !== 1'b0) begin bad++; $display("FAIL fetch_with_done: got %b want 0", bus1.instr_valid); end
    step();
    fetch_req = 1'b0;
    total++; if (bus1.instr_valid !== 1'b1 || bus1.instr !== 16'hBEEF) begin
      bad++; $display("FAIL same_cycle_fetch: got valid=%b instr=%h want 1/BEEF", bus1.instr_valid, bus1.instr);
    end
    step(); step();
    total++; if (bus3.instr_valid !== 1'b1 || bus3.instr !== 16'hBEEF) begin
      bad++; $display("FAIL same_cycle_lat3: got valid=%b instr=%h want 1/BEEF", bus3.instr_valid, bus3.instr);
    end
  endtask

  task automatic test_random();
    rst = 1'b1; idle_inputs(); step(); rst = 1'b0;
    for (int c = 0; c < 800; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      load_en    = m_run ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 1) == 1);
      load_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
      load_data  = 16'($urandom);
      load_done  = ($urandom_range(0, 19) == 0);
      fetch_req  = ($urandom_range(0, 3) != 0);
      instr_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
      step();
      total++; if (bus1.ready !== m_run || bus1.load_err !== m_err) begin
        bad++; $display("FAIL rnd_ctrl@%0d: got ready=%b err=%b want %b/%b", n, bus1.ready, bus1.load_err, m_run, m_err);
      end
      total++; if (bus1.instr_valid !== e_v1 || bus1.instr !== e_i1) begin
        bad++; $display("FAIL rnd_lat1@%0d: got valid=%b instr=%h want %b/%h", n, bus1.instr_valid, bus1.instr, e_v1, e_i1);
      end
      total++; if (bus3.instr_valid !== e_v3 || bus3.instr !== e_i3) begin
        bad++; $display("FAIL rnd_lat3@%0d: got valid=%b instr=%h want %b/%h", n, bus3.instr_valid, bus3.instr, e_v3, e_i3);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_back_to_back();
    test_err_and_load_ignore();
    test_flush();
    test_load_done_same_cycle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
